// File: rtl/param_restoring_divider_if.sv
// Handshake/operand bundle for param_restoring_divider.
// The sgn member and its modport entries exist only when SIGNED_DIV_EN is defined.
interface param_restoring_divider_if #(
    parameter int N = 8
);
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
`ifdef SIGNED_DIV_EN
    logic           sgn;
`endif
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic           overflow;

`ifdef SIGNED_DIV_EN
    modport master (output start, dividend, divisor, sgn,
                    input  quotient, remainder, busy, done, div_by_zero, overflow);
    modport slave  (input  start, dividend, divisor, sgn,
                    output quotient, remainder, busy, done, div_by_zero, overflow);
`else
    modport master (output start, dividend, divisor,
                    input  quotient, remainder, busy, done, div_by_zero, overflow);
    modport slave  (input  start, dividend, divisor,
                    output quotient, remainder, busy, done, div_by_zero, overflow);
`endif
endinterface

// File: rtl/param_restoring_divider.sv
// Sequential restoring divider, 2N/N -> N quotient + N remainder, one quotient bit per clock.
// Optional two's-complement mode compiled in with `define SIGNED_DIV_EN.
//
//  state  | meaning
//  S_IDLE | waiting for start; captures operands and screens for errors
//  S_ITER | N shift/subtract iterations
//  S_FIX  | sign correction and signed range check (SIGNED_DIV_EN only)
//  S_DONE | one-cycle done pulse, results valid
module param_restoring_divider #(
    parameter int N = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    param_restoring_divider_if.slave s_bus
);
    localparam int CNT_W = $clog2(N + 1);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_div;
    logic [N-1:0]     r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_ovf;

    logic [2*N-1:0]   w_dvd;
    logic [N-1:0]     w_dvs;
    logic             w_dvs_zero;
    logic             w_hi_ovf;
    logic [N:0]       w_shift;
    logic [N-1:0]     w_sub;
    logic             w_qbit;
    logic [N-1:0]     w_rem_next;
    logic [N-1:0]     w_quo_next;

`ifdef SIGNED_DIV_EN
    localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
    logic r_smode;
    logic r_neg_q;
    logic r_neg_r;
    logic w_fix_ovf;

    assign w_dvd = (s_bus.sgn && s_bus.dividend[2*N-1]) ? -s_bus.dividend : s_bus.dividend;
    assign w_dvs = (s_bus.sgn && s_bus.divisor[N-1])    ? -s_bus.divisor  : s_bus.divisor;
    // negative quotients may reach 2^(N-1), positive ones only 2^(N-1)-1
    assign w_fix_ovf = r_smode && (r_neg_q ? (r_quo > HALF) : r_quo[N-1]);
`else
    assign w_dvd = s_bus.dividend;
    assign w_dvs = s_bus.divisor;
`endif

    assign w_dvs_zero = (s_bus.divisor == '0);
    assign w_hi_ovf   = (w_dvd[2*N-1:N] >= w_dvs);

    // partial remainder stays below the divisor, so its top bit is never stored
    assign w_shift    = {r_rem, r_quo[N-1]};
    assign w_qbit     = (w_shift >= {1'b0, r_div});
    assign w_sub      = w_shift[N-1:0] - r_div;
    assign w_rem_next = w_qbit ? w_sub : w_shift[N-1:0];
    assign w_quo_next = {r_quo[N-2:0], w_qbit};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_smode     <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_bus.start) begin
                        r_dbz <= 1'b0;
                        r_ovf <= 1'b0;
`ifdef SIGNED_DIV_EN
                        r_smode <= s_bus.sgn;
                        r_neg_q <= s_bus.sgn & (s_bus.dividend[2*N-1] ^ s_bus.divisor[N-1]);
                        r_neg_r <= s_bus.sgn & s_bus.dividend[2*N-1];
`endif
                        if (w_hi_ovf) begin
                            r_dbz       <= w_dvs_zero;
                            r_ovf       <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rem   <= w_dvd[2*N-1:N];
                            r_quo   <= w_dvd[N-1:0];
                            r_div   <= w_dvs;
                            r_cnt   <= CNT_W'(N);
                            r_busy  <= 1'b1;
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
                        r_state <= S_FIX;
`else
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next;
                        r_state     <= S_DONE;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                    if (w_fix_ovf) begin
                        r_ovf       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= r_neg_q ? -r_quo : r_quo;
                        r_remainder <= r_neg_r ? -r_rem : r_rem;
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_bus.quotient    = r_quotient;
    assign s_bus.remainder   = r_remainder;
    assign s_bus.busy        = r_busy;
    assign s_bus.done        = r_done;
    assign s_bus.div_by_zero = r_dbz;
    assign s_bus.overflow    = r_ovf;
endmodule
